case_3_mul_share_arb: RTL and testbench

//  Round-robin arbiter and sequencer that shares one combinational signed

---
 rtl/case_3_mul_share_arb_if.sv | 33 +++
 rtl/case_3_mul_share_arb.sv | 118 +++++++++++
 tb/tb_case_3_mul_share_arb.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/case_3_mul_share_arb_if.sv
// Bundle of the requester, result and shared-multiplier signals of the arbiter.
// The master modport is the arbiter side; the slave modport is the surrounding system.
interface case_3_mul_share_arb_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 7,
    parameter int B_WIDTH  = 4,
    parameter int P_WIDTH  = 11
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;

    logic [A_WIDTH-1:0]         mul_din0;
    logic [B_WIDTH-1:0]         mul_din1;
    logic [P_WIDTH-1:0]         mul_dout;

    logic                       res_valid;
    logic                       res_ready;
    logic [P_WIDTH-1:0]         res_data;
    logic [ID_WIDTH-1:0]        res_id;

    modport master (
        input  req_valid, req_a, req_b, mul_dout, res_ready,
        output req_ready, mul_din0, mul_din1, res_valid, res_data, res_id
    );

    modport slave (
        output req_valid, req_a, req_b, mul_dout, res_ready,
        input  req_ready, mul_din0, mul_din1, res_valid, res_data, res_id
    );
endinterface

// File: rtl/case_3_mul_share_arb.sv
// Round-robin arbiter sharing one external combinational signed multiplier among
// NUM_REQ requesters; two-stage OP/RES pipeline with tagged results.
module case_3_mul_share_arb #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 7,
    parameter int B_WIDTH  = 4,
    parameter int P_WIDTH  = 11
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    case_3_mul_share_arb_if.master  bus
);
    localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

    // Pipeline state
    logic                op_valid_reg;
    logic [A_WIDTH-1:0]  op_a_reg;
    logic [B_WIDTH-1:0]  op_b_reg;
    logic [ID_WIDTH-1:0] op_id_reg;
    logic                res_valid_reg;
    logic [P_WIDTH-1:0]  res_data_reg;
    logic [ID_WIDTH-1:0] res_id_reg;
    logic [ID_WIDTH-1:0] rr_ptr_reg;

    logic                adv_res;
    logic                adv_op;
    logic                handshake;
    logic                grant_any;
    logic [ID_WIDTH-1:0] grant_id;
    logic [ID_WIDTH-1:0] rr_ptr_next;

    logic [A_WIDTH-1:0]  req_a_arr [NUM_REQ];
    logic [B_WIDTH-1:0]  req_b_arr [NUM_REQ];
    logic [ID_WIDTH-1:0] cand_id   [NUM_REQ];
    logic [NUM_REQ-1:0]  cand_valid;

    assign adv_res   = !res_valid_reg || bus.res_ready;
    assign adv_op    = !op_valid_reg || adv_res;
    assign handshake = grant_any && adv_op;

    // Unpack operands and build the scan order starting at rr_ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            localparam logic [ID_WIDTH:0] OFFSET = (ID_WIDTH+1)'(gi);
            logic [ID_WIDTH:0] scan_sum;

            assign req_a_arr[gi] = bus.req_a[gi*A_WIDTH +: A_WIDTH];
            assign req_b_arr[gi] = bus.req_b[gi*B_WIDTH +: B_WIDTH];

            assign scan_sum       = {1'b0, rr_ptr_reg} + OFFSET;
            assign cand_id[gi]    = (scan_sum >= NUM_REQ_W) ? ID_WIDTH'(scan_sum - NUM_REQ_W)
                                                            : scan_sum[ID_WIDTH-1:0];
            assign cand_valid[gi] = bus.req_valid[cand_id[gi]];
        end
    endgenerate

    // Lowest scan position wins, so iterate from the far end down.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_valid[k[ID_WIDTH-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand_id[k[ID_WIDTH-1:0]];
            end
        end
    end

    assign rr_ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    // Ready is forced low while reset is held since adv_op is 1 with an empty pipe.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(gi);
            assign bus.req_ready[gi] = ap_rst_n && handshake && (grant_id == MY_ID);
        end
    endgenerate

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            op_valid_reg  <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_id_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_id_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            if (adv_res) begin
                res_valid_reg <= op_valid_reg;
                if (op_valid_reg) begin
                    res_data_reg <= bus.mul_dout;
                    res_id_reg   <= op_id_reg;
                end
            end
            if (adv_op) begin
                op_valid_reg <= handshake;
                if (handshake) begin
                    op_a_reg  <= req_a_arr[grant_id];
                    op_b_reg  <= req_b_arr[grant_id];
                    op_id_reg <= grant_id;
                end
            end
            if (handshake) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign bus.mul_din0  = op_a_reg;
    assign bus.mul_din1  = op_b_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign bus.res_id    = res_id_reg;
endmodule

// File: tb/tb_case_3_mul_share_arb.sv
// Bench for case_3_mul_share_arb: directed scenarios plus random traffic,
// checked every cycle against a round-robin / two-entry-buffer scoreboard model.
module tb_case_3_mul_share_arb;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 7;
    localparam int BW = 4;
    localparam int PW = 11;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b1;
    always #5 ap_clk = ~ap_clk;

    case_3_mul_share_arb_if #(.NUM_REQ(N), .ID_WIDTH(IW), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

    case_3_mul_share_arb #(.NUM_REQ(N), .ID_WIDTH(IW), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    // Shared combinational multiplier
    logic signed [PW-1:0] mul_a_ext;
    logic signed [PW-1:0] mul_b_ext;
    assign mul_a_ext    = PW'($signed(bus.mul_din0));
    assign mul_b_ext    = PW'($signed(bus.mul_din1));
    assign bus.mul_dout = mul_a_ext * mul_b_ext;

    typedef struct {
        int id;
        int prod;
        int edge_n;
    } item_t;

    item_t q[$];
    int    rr_m;
    int    edge_cnt;
    int    n_checks;
    int    n_fail;
    int    av[N];
    int    bv[N];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against model, then advance the model at the edge.
    task automatic step(input logic [N-1:0] v, input logic rdy);
        int            g;
        bit            any;
        bit            exp_valid;
        bit            acc;
        bit            cons;
        logic [N-1:0]  exp_rdy;
        bus.req_valid = v;
        bus.res_ready = rdy;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*AW +: AW] = AW'(av[i]);
            bus.req_b[i*BW +: BW] = BW'(bv[i]);
        end
        any = 0;
        g   = 0;
        for (int k = 0; k < N; k++) begin
            if (!any && v[(rr_m + k) % N]) begin
                any = 1;
                g   = (rr_m + k) % N;
            end
        end
        exp_rdy = '0;
        if (any && (q.size() < 2 || rdy)) exp_rdy[g] = 1'b1;
        exp_valid = (q.size() > 0) && (q[0].edge_n < edge_cnt);
        #2;
        check("req_ready", int'(bus.req_ready), int'(exp_rdy));
        check("res_valid", int'(bus.res_valid), int'(exp_valid));
        if (exp_valid) begin
            check("res_data", int'($signed(bus.res_data)), q[0].prod);
            check("res_id", int'(bus.res_id), q[0].id);
        end
        acc  = (exp_rdy != '0);
        cons = exp_valid && rdy;
        @(posedge ap_clk);
        edge_cnt++;
        if (cons) begin
            $display("txn result id=%0d prod=%0d", q[0].id, q[0].prod);
            void'(q.pop_front());
        end
        if (acc) begin
            q.push_back('{id: g, prod: av[g] * bv[g], edge_n: edge_cnt});
            rr_m = (g + 1) % N;
        end
        @(negedge ap_clk);
    endtask

    task automatic drain();
        repeat (3) step('0, 1'b1);
        check("drained", q.size(), 0);
    endtask

    // Reset held over one rising edge; the outputs must drop as soon as it asserts.
    task automatic apply_reset(input string tag);
        bus.req_valid = '1;
        bus.res_ready = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        check({tag, "_res_valid"}, int'(bus.res_valid), 0);
        check({tag, "_req_ready"}, int'(bus.req_ready), 0);
        check({tag, "_mul_din0"}, int'(bus.mul_din0), 0);
        check({tag, "_mul_din1"}, int'(bus.mul_din1), 0);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        q.delete();
        rr_m = 0;
    endtask

    int ea[4] = '{63, -64, 63, 0};
    int eb[4] = '{7, 7, -8, -8};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rr_m     = 0;
        edge_cnt = 0;
        for (int i = 0; i < N; i++) begin
            av[i] = 0;
            bv[i] = 0;
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #1;
        @(negedge ap_clk);
        apply_reset("init");

        // Single product from requester 0
        av[0] = -64; bv[0] = -8;
        step(4'b0001, 1'b1);
        drain();

        // Fairness with all requesters active
        apply_reset("rst2");
        av = '{5, -7, 33, -20};
        bv = '{3, -2, 7, -8};
        repeat (6) step('1, 1'b1);
        drain();

        // Pointer at 2 with only requesters 1 and 3 valid
        step(4'b0010, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b1);
        drain();

        // Backpressure on a requester-2 stream
        for (int i = 0; i < 5; i++) begin
            av[2] = int'($urandom_range(0, 127)) - 64;
            bv[2] = int'($urandom_range(0, 15)) - 8;
            step(4'b0100, 1'b0);
        end
        repeat (4) step(4'b0100, 1'b1);
        drain();

        // Operand extremes
        for (int i = 0; i < 4; i++) begin
            av[0] = ea[i];
            bv[0] = eb[i];
            step(4'b0001, 1'b1);
        end
        drain();

        // Reset with both stages full
        av[2] = 17; bv[2] = -3;
        repeat (3) step(4'b0100, 1'b0);
        check("full_before_reset", q.size(), 2);
        apply_reset("midflight");
        av[0] = 9; bv[0] = 5;
        step('1, 1'b1);
        drain();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                av[i] = int'($urandom_range(0, 127)) - 64;
                bv[i] = int'($urandom_range(0, 15)) - 8;
            end
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        repeat (2) step('0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
